trees_feeder: RTL

TREES_FEEDER -- requirements
Module: trees_feeder

---
 rtl/trees_feeder.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/trees_feeder.sv
// Feeds tree-ensemble node words and feature vectors from a 64-bit stream into the inference engine.
// Latency: one cycle from stream handshake to node write strobe; result is registered one cycle after done.
// Backpressure: s_ready is high only while loading or collecting features; r_valid holds until r_ready.
// Optional inference watchdog: define TREES_FEEDER_TIMEOUT_EN.
module trees_feeder #(
   parameter int N_TREES          = 16,
   parameter int N_NODE_AND_LEAFS = 256,
   parameter int N_FEATURE        = 32,
   parameter int TIMEOUT_CYCLES   = 4096
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                load_cmd,
   input  logic                                infer_cmd,
   input  logic                                s_valid,
   output logic                                s_ready,
   input  logic [63:0]                         s_data,
   output logic                                load_trees,
   output logic [$clog2(N_NODE_AND_LEAFS)-1:0] n_node,
   output logic [$clog2(N_TREES)-1:0]          n_tree,
   output logic [63:0]                         tree_nodes,
   output logic [N_FEATURE*32-1:0]             features,
   output logic                                start,
   input  logic                                done,
   input  logic [7:0]                          prediction,
   input  logic                                idle_sys,
   output logic                                r_valid,
   input  logic                                r_ready,
   output logic [7:0]                          r_data,
   output logic                                r_err,
   output logic                                busy
);

   localparam int NW = $clog2(N_NODE_AND_LEAFS);
   localparam int TW = $clog2(N_TREES);
   localparam int FW = (N_FEATURE > 2) ? $clog2(N_FEATURE / 2) : 1;

   localparam logic [NW-1:0] NODE_LAST = NW'(N_NODE_AND_LEAFS - 1);
   localparam logic [TW-1:0] TREE_LAST = TW'(N_TREES - 1);
   localparam logic [FW-1:0] FEAT_LAST = FW'(N_FEATURE / 2 - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FEAT,
      ST_START,
      ST_WAIT,
      ST_RESULT
   } state_t;

   state_t                  state_q, state_d;
   logic [NW-1:0]           wr_node_q, wr_node_d;
   logic [TW-1:0]           wr_tree_q, wr_tree_d;
   logic [FW-1:0]           feat_idx_q, feat_idx_d;
   logic                    s_ready_q, s_ready_d;
   logic                    load_trees_q, load_trees_d;
   logic [NW-1:0]           n_node_q, n_node_d;
   logic [TW-1:0]           n_tree_q, n_tree_d;
   logic [63:0]             tree_nodes_q, tree_nodes_d;
   logic [N_FEATURE*32-1:0] features_q, features_d;
   logic                    start_q, start_d;
   logic                    r_valid_q, r_valid_d;
   logic [7:0]              r_data_q, r_data_d;
   logic                    busy_q, busy_d;
   logic                    accept;

`ifdef TREES_FEEDER_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] to_cnt_q, to_cnt_d;
   logic          r_err_q, r_err_d;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

   assign accept = s_valid & s_ready_q;

   always_comb begin
      state_d      = state_q;
      wr_node_d    = wr_node_q;
      wr_tree_d    = wr_tree_q;
      feat_idx_d   = feat_idx_q;
      load_trees_d = 1'b0;
      n_node_d     = n_node_q;
      n_tree_d     = n_tree_q;
      tree_nodes_d = tree_nodes_q;
      features_d   = features_q;
      start_d      = 1'b0;
      r_data_d     = r_data_q;
`ifdef TREES_FEEDER_TIMEOUT_EN
      to_cnt_d     = to_cnt_q;
      r_err_d      = r_err_q;
`endif

      case (state_q)
         ST_IDLE: begin
            // load wins over a simultaneous infer request
            if (load_cmd) begin
               state_d   = ST_LOAD;
               wr_node_d = '0;
               wr_tree_d = '0;
            end else if (infer_cmd) begin
               state_d    = ST_FEAT;
               feat_idx_d = '0;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               load_trees_d = 1'b1;
               tree_nodes_d = s_data;
               n_node_d     = wr_node_q;
               n_tree_d     = wr_tree_q;
               if (wr_node_q == NODE_LAST) begin
                  wr_node_d = '0;
                  if (wr_tree_q == TREE_LAST) begin
                     state_d = ST_IDLE;
                  end else begin
                     wr_tree_d = wr_tree_q + TW'(1);
                  end
               end else begin
                  wr_node_d = wr_node_q + NW'(1);
               end
            end
         end
         ST_FEAT: begin
            if (accept) begin
               features_d[int'(feat_idx_q)*64 +: 64] = s_data;
               if (feat_idx_q == FEAT_LAST) begin
                  state_d = ST_START;
               end else begin
                  feat_idx_d = feat_idx_q + FW'(1);
               end
            end
         end
         ST_START: begin
            if (idle_sys) begin
               start_d = 1'b1;
               state_d = ST_WAIT;
`ifdef TREES_FEEDER_TIMEOUT_EN
               to_cnt_d = '0;
`endif
            end
         end
         ST_WAIT: begin
            if (done) begin
               r_data_d = prediction;
               state_d  = ST_RESULT;
`ifdef TREES_FEEDER_TIMEOUT_EN
               r_err_d  = 1'b0;
            end else if (to_cnt_q == TO_LAST) begin
               r_data_d = 8'hFF;
               r_err_d  = 1'b1;
               state_d  = ST_RESULT;
            end else begin
               to_cnt_d = to_cnt_q + CW'(1);
`endif
            end
         end
         ST_RESULT: begin
            if (r_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // handshake-facing flags follow the next state so they are registered
      s_ready_d = (state_d == ST_LOAD) || (state_d == ST_FEAT);
      r_valid_d = (state_d == ST_RESULT);
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         wr_node_q    <= '0;
         wr_tree_q    <= '0;
         feat_idx_q   <= '0;
         s_ready_q    <= 1'b0;
         load_trees_q <= 1'b0;
         n_node_q     <= '0;
         n_tree_q     <= '0;
         tree_nodes_q <= '0;
         features_q   <= '0;
         start_q      <= 1'b0;
         r_valid_q    <= 1'b0;
         r_data_q     <= '0;
         busy_q       <= 1'b0;
`ifdef TREES_FEEDER_TIMEOUT_EN
         to_cnt_q     <= '0;
         r_err_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         wr_node_q    <= wr_node_d;
         wr_tree_q    <= wr_tree_d;
         feat_idx_q   <= feat_idx_d;
         s_ready_q    <= s_ready_d;
         load_trees_q <= load_trees_d;
         n_node_q     <= n_node_d;
         n_tree_q     <= n_tree_d;
         tree_nodes_q <= tree_nodes_d;
         features_q   <= features_d;
         start_q      <= start_d;
         r_valid_q    <= r_valid_d;
         r_data_q     <= r_data_d;
         busy_q       <= busy_d;
`ifdef TREES_FEEDER_TIMEOUT_EN
         to_cnt_q     <= to_cnt_d;
         r_err_q      <= r_err_d;
`endif
      end
   end

   assign s_ready    = s_ready_q;
   assign load_trees = load_trees_q;
   assign n_node     = n_node_q;
   assign n_tree     = n_tree_q;
   assign tree_nodes = tree_nodes_q;
   assign features   = features_q;
   assign start      = start_q;
   assign r_valid    = r_valid_q;
   assign r_data     = r_data_q;
   assign busy       = busy_q;
`ifdef TREES_FEEDER_TIMEOUT_EN
   assign r_err      = r_err_q;
`else
   assign r_err      = 1'b0;
`endif

endmodule
